// File: rtl/tbec_encoder_pipe.sv
// Two-stage streaming TBEC encoder: 16-bit data beats in, 32-bit codewords out,
// with optional per-beat XOR fault injection applied in the output stage.
module tbec_encoder_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             inj_en,
  input  logic [31:0]      inj_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             out_injected,
  output logic [CNT_W-1:0] word_count
);

  // Builds the clean codeword; field order matches what tbec_decoder unpacks.
  function automatic logic [31:0] tbec_encode(input logic [15:0] d);
    logic a1, a2, a3, a4;
    logic b1, b2, b3, b4;
    logic c1, c2, c3, c4;
    logic d1, d2, d3, d4;
    logic di1, di2, di3, di4;
    logic p1, p2, p3, p4;
    logic [7:0] xchk;
    {a1, a2, a3, a4} = {d[15], d[11], d[7], d[3]};
    {b1, b2, b3, b4} = {d[14], d[10], d[6], d[2]};
    {c1, c2, c3, c4} = {d[13], d[9],  d[5], d[1]};
    {d1, d2, d3, d4} = {d[12], d[8],  d[4], d[0]};
    di1 = a1 ^ b2 ^ c1 ^ d2;
    di2 = a2 ^ b1 ^ c2 ^ d1;
    di3 = a3 ^ b4 ^ c3 ^ d4;
    di4 = a4 ^ b3 ^ c4 ^ d3;
    p1 = a1 ^ a2 ^ b1 ^ b2;
    p2 = c1 ^ c2 ^ d1 ^ d2;
    p3 = a3 ^ a4 ^ b3 ^ b4;
    p4 = c3 ^ c4 ^ d3 ^ d4;
    xchk = {a1 ^ a3, a2 ^ a4, b1 ^ b3, b2 ^ b4,
            c1 ^ c3, c2 ^ c4, d1 ^ d3, d2 ^ d4};
    return {d, di1, di4, di2, di3, p1, p4, p2, p3, xchk};
  endfunction

  logic        vld_p1;
  logic [31:0] cw_p1;
  logic        inj_en_p1;
  logic [31:0] inj_mask_p1;
  logic        s1_load;
  logic        s2_load;

  assign in_ready = !vld_p1 || !out_valid || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = vld_p1 && (!out_valid || out_ready);

  // Stage 1: clean codeword plus the injection controls captured with the beat
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (s1_load) begin
      vld_p1 <= 1'b1;
    end else if (s2_load) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      cw_p1       <= tbec_encode(in_data);
      inj_en_p1   <= inj_en;
      inj_mask_p1 <= inj_mask;
    end
  end

  // Stage 2: corruption is applied here so stage 1 always holds the clean word
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_word     <= '0;
      out_injected <= 1'b0;
    end else if (s2_load) begin
      out_valid    <= 1'b1;
      out_word     <= cw_p1 ^ (inj_en_p1 ? inj_mask_p1 : 32'h0);
      out_injected <= inj_en_p1 && (inj_mask_p1 != 32'h0);
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= '0;
    end else if (out_valid && out_ready) begin
      word_count <= word_count + 1'b1;
    end
  end

endmodule
